// File: rtl/hamming_pkg.sv
// Shared definitions for the extended-Hamming (SECDED) codec family.
// Parity-width sizing, status codes and codeword position helpers.
package hamming_pkg;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_CORR   = 2'b01;
    localparam logic [1:0] ST_UNCORR = 2'b10;

    function automatic int par_w(input int data_w);
        int r;
        r = 1;
        while ((2 ** r) < (data_w + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic is_pow2(input int x);
        return (x > 0) && ((x & (x - 1)) == 0);
    endfunction

    // Hamming position of data bit i: the i-th non-power-of-two index.
    function automatic int data_pos(input int i);
        int p;
        int cnt;
        p   = 0;
        cnt = -1;
        while (cnt < i) begin
            p = p + 1;
            if (!is_pow2(p)) begin
                cnt = cnt + 1;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/parity core shared by the encode and decode paths.
// S = XOR of the indices of set bits 1..CODE_W-1, P = XOR of all bits.
module hamming_syndrome #(
    parameter int CODE_W = 8,
    parameter int PAR_W  = 3
) (
    input  logic [CODE_W-1:0] word,
    output logic [PAR_W-1:0]  syn,
    output logic              par
);

    always_comb begin
        syn = '0;
        for (int p = 1; p < CODE_W; p++) begin
            if (word[p]) begin
                syn = syn ^ PAR_W'(p);
            end
        end
    end

    assign par = ^word;

endmodule

// File: rtl/hamming_secded_stream.sv
// Streaming SECDED Hamming encoder/decoder, 2-stage elastic pipeline
// with saturating corrected/uncorrectable result counters.
module hamming_secded_stream
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8,
    localparam int PAR_W  = par_w(DATA_W),
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_word,
    output logic [1:0]        out_status,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              adv;
    logic              fire;
    logic [CODE_W-1:0] scat;
    logic [CODE_W-1:0] syn_in;
    logic [PAR_W-1:0]  syn;
    logic              par;

    logic              s1_valid;
    logic              s1_mode;
    logic [CODE_W-1:0] s1_word;
    logic [PAR_W-1:0]  s1_syn;
    logic              s1_par;

    logic [CODE_W-1:0] cw;
    logic [CODE_W-1:0] fixed;
    logic [DATA_W-1:0] dat;
    logic [1:0]        st;
    logic [CODE_W-1:0] nxt_word;
    logic [1:0]        nxt_status;
    logic [PAR_W-1:0]  nxt_syn;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign fire     = out_valid && out_ready;

    always_comb begin
        scat = '0;
        for (int i = 0; i < DATA_W; i++) begin
            scat[data_pos(i)] = in_word[i];
        end
    end

    // Encode runs the scattered data (parity slots zero) through the
    // same syndrome core: the syndrome bits are then the parity bits.
    assign syn_in = in_mode ? in_word : scat;

    hamming_syndrome #(
        .CODE_W(CODE_W),
        .PAR_W (PAR_W)
    ) u_syn (
        .word(syn_in),
        .syn (syn),
        .par (par)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_word  <= '0;
            s1_syn   <= '0;
            s1_par   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mode <= in_mode;
                s1_word <= syn_in;
                s1_syn  <= syn;
                s1_par  <= par;
            end
        end
    end

    always_comb begin
        cw = s1_word;
        for (int k = 0; k < PAR_W; k++) begin
            cw[2 ** k] = s1_syn[k];
        end
        cw[0] = s1_par ^ (^s1_syn);

        fixed = s1_word;
        st    = ST_OK;
        if (s1_par) begin
            if (int'(s1_syn) < CODE_W) begin
                fixed[s1_syn] = ~fixed[s1_syn];
                st            = ST_CORR;
            end else begin
                st = ST_UNCORR;
            end
        end else if (s1_syn != '0) begin
            st = ST_UNCORR;
        end

        dat = '0;
        for (int i = 0; i < DATA_W; i++) begin
            dat[i] = fixed[data_pos(i)];
        end

        if (s1_mode) begin
            nxt_word   = {{(CODE_W-DATA_W){1'b0}}, dat};
            nxt_status = st;
            nxt_syn    = s1_syn;
        end else begin
            nxt_word   = cw;
            nxt_status = ST_OK;
            nxt_syn    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_word     <= '0;
            out_status   <= ST_OK;
            out_syndrome <= '0;
        end else if (adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_word     <= nxt_word;
                out_status   <= nxt_status;
                out_syndrome <= nxt_syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_corr   <= '0;
            cnt_uncorr <= '0;
        end else if (fire) begin
            if (out_status == ST_CORR && cnt_corr != CNT_MAX) begin
                cnt_corr <= cnt_corr + 1'b1;
            end
            if (out_status == ST_UNCORR && cnt_uncorr != CNT_MAX) begin
                cnt_uncorr <= cnt_uncorr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Bench for hamming_secded_stream (DATA_W=4): directed spec vectors plus
// randomized traffic scored against a position-level Hamming model.
module tb_hamming_secded_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_mode = 1'b0;
    logic [7:0] in_word = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_word;
    logic [1:0] out_status;
    logic [2:0] out_syndrome;
    logic       clr_cnt = 1'b0;
    logic [7:0] cnt_corr;
    logic [7:0] cnt_uncorr;

    typedef struct packed {
        logic [7:0] w;
        logic [1:0] st;
        logic [2:0] syn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_out = 0;
    int   exp_corr = 0;
    int   exp_unc = 0;
    int   rdy_mode = 0;
    logic mon_en = 1'b0;
    logic prev_stall = 1'b0;
    exp_t prev;

    hamming_secded_stream #(
        .DATA_W(4),
        .CNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_word     (in_word),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_status  (out_status),
        .out_syndrome(out_syndrome),
        .clr_cnt     (clr_cnt),
        .cnt_corr    (cnt_corr),
        .cnt_uncorr  (cnt_uncorr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_encode(input logic [3:0] d);
        logic [7:0] c;
        logic       x;
        int         k;
        c = '0;
        k = 0;
        for (int p = 1; p < 8; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 3; b++) begin
            x = 1'b0;
            for (int p = 1; p < 8; p++) begin
                if (((p >> b) & 1) == 1) x = x ^ c[p];
            end
            c[1 << b] = x;
        end
        c[0] = ^c[7:1];
        return c;
    endfunction

    function automatic logic [3:0] ref_extract(input logic [7:0] c);
        logic [3:0] d;
        int         k;
        d = '0;
        k = 0;
        for (int p = 1; p < 8; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    function automatic exp_t mk(input logic [7:0] w, input logic [1:0] st,
                                input logic [2:0] syn);
        exp_t e;
        e.w   = w;
        e.st  = st;
        e.syn = syn;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !out_ready;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard: compare delivered results, stall stability, counters.
    always @(negedge clk) begin
        exp_t e;
        logic got;
        #2;
        if (rst) begin
            exp_q.delete();
            exp_corr   = 0;
            exp_unc    = 0;
            prev_stall = 1'b0;
        end else if (mon_en) begin
            chk("cnt_corr", 32'(cnt_corr), exp_corr);
            chk("cnt_uncorr", 32'(cnt_uncorr), exp_unc);
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_word", 32'(out_word), 32'(prev.w));
                chk("stall_status", 32'(out_status), 32'(prev.st));
                chk("stall_syn", 32'(out_syndrome), 32'(prev.syn));
            end
            got = 1'b0;
            if (out_valid && out_ready) begin
                n_out++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL unexpected_output observed=%0h expected=none",
                           out_word);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    got = 1'b1;
                    chk("out_word", 32'(out_word), 32'(e.w));
                    chk("out_status", 32'(out_status), 32'(e.st));
                    chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
                end
            end
            if (clr_cnt) begin
                exp_corr = 0;
                exp_unc  = 0;
            end else if (got) begin
                if (e.st == 2'b01 && exp_corr < 255) exp_corr++;
                if (e.st == 2'b10 && exp_unc < 255) exp_unc++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = mk(out_word, out_status, out_syndrome);
        end
    end

    task automatic send(input logic m, input logic [7:0] w, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = m;
        in_word  = w;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (in_ready) else begin
            failures++;
            $error("FAIL accept_timeout observed=%0d expected=ready", in_ready);
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_enc(input logic [3:0] d);
        send(1'b0, {4'($urandom), d}, mk(ref_encode(d), 2'b00, 3'd0));
    endtask

    task automatic do_dec(input logic [3:0] d, input int nerr);
        logic [7:0] c;
        int         e1;
        int         e2;
        exp_t       e;
        c  = ref_encode(d);
        e1 = $urandom_range(0, 7);
        e2 = (e1 + $urandom_range(1, 7)) % 8;
        if (nerr == 0) begin
            e = mk({4'h0, d}, 2'b00, 3'd0);
        end else if (nerr == 1) begin
            c[e1] = ~c[e1];
            e = mk({4'h0, d}, 2'b01, e1[2:0]);
        end else begin
            c[e1] = ~c[e1];
            c[e2] = ~c[e2];
            e = mk({4'h0, ref_extract(c)}, 2'b10, 3'(e1 ^ e2));
        end
        send(1'b1, c, e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
    endtask

    initial begin
        int n;
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_word", 32'(out_word), 0);
        chk("rst_status", 32'(out_status), 0);
        chk("rst_syndrome", 32'(out_syndrome), 0);
        chk("rst_cnt_corr", 32'(cnt_corr), 0);
        chk("rst_cnt_uncorr", 32'(cnt_uncorr), 0);
        mon_en = 1'b1;

        send(1'b0, 8'h0B, mk(8'hAA, 2'b00, 3'd0));
        n = 0;
        do begin
            @(negedge clk);
            #3;
            n++;
        end while (!out_valid && n < 10);
        chk("latency", cyc - acc_cyc, 2);
        drain();

        send(1'b1, 8'hAA, mk(8'h0B, 2'b00, 3'd0));
        send(1'b1, 8'h8A, mk(8'h0B, 2'b01, 3'd5));
        drain();
        chk("t2_cnt_corr", 32'(cnt_corr), 1);

        send(1'b1, 8'hAB, mk(8'h0B, 2'b01, 3'd0));
        send(1'b1, 8'hCA, mk(8'h0D, 2'b10, 3'd3));
        drain();
        chk("t3_cnt_corr", 32'(cnt_corr), 2);
        chk("t3_cnt_uncorr", 32'(cnt_uncorr), 1);

        rdy_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 16; i++) do_enc(4'(i));
        drain();
        chk("t4_count", n_out - n0, 16);

        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            if ($urandom_range(0, 2) == 0) do_enc(4'($urandom));
            else do_dec(4'($urandom), $urandom_range(0, 2));
        end
        do_dec(4'h6, 1);
        do_dec(4'h9, 2);
        drain();

        rdy_mode = 3;
        repeat (2) @(negedge clk);
        do_dec(4'h5, 1);
        do_dec(4'h9, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #3;
        chk("t6_out_valid", 32'(out_valid), 0);
        chk("t6_cnt_corr", 32'(cnt_corr), 0);
        chk("t6_cnt_uncorr", 32'(cnt_uncorr), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        n0 = n_out;
        rdy_mode = 0;
        repeat (8) @(negedge clk);
        #3;
        chk("t6_no_stale", n_out - n0, 0);

        clr_pulse();
        for (int i = 0; i < 260; i++) do_dec(4'($urandom), 1);
        drain();
        chk("t5_saturate", 32'(cnt_corr), 255);
        clr_pulse();
        do_dec(4'h3, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        @(negedge clk);
        #3;
        chk("t5_clr_wins", 32'(cnt_corr), 0);
        chk("t5_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
